// File: rtl/piso_serializer_if.sv
// piso_serializer_if
//   Load handshake and serial output bundle for piso_serializer.
//   master : the word source / serial consumer side (drives load and enable)
//   slave  : the serializer itself
//   Signals:
//     i_load_valid / i_data / o_load_ready : parallel word load handshake
//     i_en                                 : bit-advance enable
//     o_dat / o_valid / o_last / o_done    : serial bit stream and framing
interface piso_serializer_if #(
    parameter int BITS = 5
);
    logic            i_load_valid;
    logic [BITS-1:0] i_data;
    logic            o_load_ready;
    logic            i_en;
    logic            o_dat;
    logic            o_valid;
    logic            o_last;
    logic            o_done;

    modport master (
        output i_load_valid,
        output i_data,
        output i_en,
        input  o_load_ready,
        input  o_dat,
        input  o_valid,
        input  o_last,
        input  o_done
    );

    modport slave (
        input  i_load_valid,
        input  i_data,
        input  i_en,
        output o_load_ready,
        output o_dat,
        output o_valid,
        output o_last,
        output o_done
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in, serial-out shift register. A BITS-wide word is taken through
//   a valid/ready handshake and emitted one bit per enabled clock on o_dat.
//   Ports:
//     clk    : system clock, all state changes on posedge
//     i_sclr : synchronous active-high clear, overrides everything
//     bus    : piso_serializer_if.slave (load handshake, enable, serial out)
//   Parameters:
//     BITS      : word width (>= 2)
//     MSB_FIRST : 1 = bit BITS-1 leaves first, 0 = bit 0 leaves first
module piso_serializer #(
    parameter int BITS      = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               i_sclr,
    piso_serializer_if.slave   bus
);
    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [BITS-1:0]  sreg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;

    // Word shifted one place toward the output end, zero-filled at the far end.
    logic [BITS-1:0]  sreg_next;

    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_left
                if (gi == 0) begin : g_fill
                    assign sreg_next[gi] = 1'b0;
                end else begin : g_move
                    assign sreg_next[gi] = sreg_reg[gi-1];
                end
            end else begin : g_right
                if (gi == BITS - 1) begin : g_fill
                    assign sreg_next[gi] = 1'b0;
                end else begin : g_move
                    assign sreg_next[gi] = sreg_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the final consuming edge sets it.
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // i_en has no effect here; only a load moves us on.
                    if (bus.i_load_valid) begin
                        sreg_reg  <= bus.i_data;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.i_en) begin
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                            sreg_reg  <= '0;
                            cnt_reg   <= '0;
                        end else begin
                            sreg_reg <= sreg_next;
                            cnt_reg  <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from registered state only, so they are glitch
    // free with respect to the inputs and settle one cycle after each edge.
    logic valid_w;
    assign valid_w          = (state_reg == SHIFT);
    assign bus.o_load_ready = (state_reg == IDLE);
    assign bus.o_valid      = valid_w;
    assign bus.o_dat        = valid_w & (MSB_FIRST ? sreg_reg[BITS-1] : sreg_reg[0]);
    assign bus.o_last       = valid_w && (cnt_reg == LAST_CNT);
    assign bus.o_done       = done_reg;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out shift register. It is the transmit end paired with the serial-in, parallel-out bshift_register. It accepts a BITS-wide word through a valid/ready load handshake and emits it one bit per enabled clock on o_dat. When o_dat and the enable are wired to a bshift_register of equal BITS, the receiver's o_data equals the loaded word after BITS enabled edges.

Parameters:
BITS, 5, word width in bits (>=2).
MSB_FIRST, 1, 1 = emit bit BITS-1 first (matches the left-shifting bshift_register); 0 = emit bit 0 first.

Ports:
clk  input  1  system clock; all state updates on posedge.
i_sclr  input  1  synchronous active-high reset; highest priority.
i_load_valid  input  1  source presents a word on i_data.
i_data  input  BITS  parallel word to serialize.
o_load_ready  output  1  block can accept a word this cycle.
i_en  input  1  bit-advance enable; the current o_dat bit is consumed at a posedge with i_en=1.
o_dat  output  1  current serial bit.
o_valid  output  1  o_dat carries a word bit.
o_last  output  1  o_dat is the final bit of the word.
o_done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Interface: one clock, clk. Reset i_sclr is synchronous and active-high.
- State: shift register sreg[BITS-1:0], bit counter cnt (width $clog2(BITS)), FSM {IDLE, SHIFT}, and registered done flag.
- Reset (posedge with i_sclr=1):
  - State goes to IDLE; sreg=0, cnt=0, done=0.
  - From the next cycle: o_load_ready=1, o_valid=0, o_last=0, o_dat=0, o_done=0.
  - i_sclr overrides load, i_en and any in-flight word.
- Combinational outputs:
  - o_load_ready = (state==IDLE).
  - o_valid = (state==SHIFT).
  - o_dat = o_valid ? (MSB_FIRST ? sreg[BITS-1] : sreg[0]) : 0.
  - o_last = o_valid && cnt==BITS-1.
  - o_done = done register.
- IDLE:
  - Posedge with i_load_valid && o_load_ready: sreg<=i_data, cnt<=0, state<=SHIFT.
  - The first bit appears on o_dat in the cycle after the load edge (latency 1).
  - i_en is ignored in IDLE.
- SHIFT:
  - Posedge with i_en=1 and cnt<BITS-1: sreg shifts toward the output end (left if MSB_FIRST, else right), zero-filled; cnt<=cnt+1.
  - Posedge with i_en=1 and cnt==BITS-1: state<=IDLE, done<=1, sreg<=0, cnt<=0.
  - i_en=0: sreg, cnt and outputs hold; there is no timeout.
  - i_load_valid is ignored (o_load_ready=0). The source must hold i_data and i_load_valid until ready.
- done is 1 for exactly the cycle after the final consuming edge, coincident with o_load_ready=1. It clears on the following edge.
- A word occupies exactly BITS enabled edges. The minimum gap between words is one IDLE cycle (load edge follows the done edge).
- The receiver samples o_dat at the same posedge where i_en=1. No extra pipeline stage sits between the two blocks.
- Reset mid-word: the word is discarded, no o_done pulse, back to IDLE.
- cnt never exceeds BITS-1, and there is no wrap path.

Test Plan:
1. Reset: i_sclr=1 for one edge, then 0 -> o_load_ready=1, o_valid=0, o_dat=0, o_last=0, o_done=0. i_en=1 alone in IDLE -> outputs unchanged.
2. Load 5'b10111, i_en=1 continuously -> o_dat 1,0,1,1,1 on the five cycles after the load edge, o_valid=1 throughout, o_last=1 only on the 5th. Next cycle: o_done=1, o_valid=0, o_load_ready=1. o_done=0 the cycle after.
3. Loopback into bshift_register #(5) (cleared, shared i_en, o_dat->i_dat): load 5'b01011 -> after 5 enabled edges the receiver o_data=5'b01011. Repeat with 5'b11110 -> 5'b11110.
4. i_en pattern 1,0,0,1,1,0,1,1 with word 5'b10010 -> o_dat holds during i_en=0. o_done fires only after the 5th enabled edge; the bit sequence is still 1,0,0,1,0.
5. Load 5'b00110. After 2 bits, assert i_load_valid with 5'b11111 -> ignored, the remaining bits are 1,1,0. Then, during a new word 5'b10101, assert i_sclr after 2 bits -> IDLE, no o_done. The following load of 5'b00001 emits 0,0,0,0,1.
6. MSB_FIRST=0, load 5'b00110 -> o_dat 0,1,1,0,0, o_last on the 5th bit, o_done next cycle.
